mouse_master_sm: RTL

// - PS/2 mouse master controller; sits directly upstream of the mouse transmitter, driving its SEND_BYTE/BYTE_TO_SEND and consuming BYTE_SENT.
// - Also consumes bytes from the mouse receiver.
// - Runs the init handshake: reset 0xFF -> ACK 0xFA -> self-test 0xAA -> ID 0x00 -> enable 0xF4 -> ACK 0xFA.
// - Then assembles 3-byte stream packets into status/dX/dY with a one-cycle interrupt to the bus interface.

---
 rtl/mouse_pkg.sv | 41 ++++
 rtl/mouse_packet_collector.sv | 71 +++++++
 rtl/mouse_master_sm.sv | 117 +++++++++++
 3 files changed

// File: rtl/mouse_pkg.sv
// Shared state encodings, protocol bytes and helpers for the PS/2 mouse master controller.
package mouse_pkg;

    typedef logic [3:0] mouse_state_t;

    localparam mouse_state_t ST_INIT          = 4'd0;
    localparam mouse_state_t ST_SEND_RST      = 4'd1;
    localparam mouse_state_t ST_WAIT_RST_TX   = 4'd2;
    localparam mouse_state_t ST_WAIT_ACK1     = 4'd3;
    localparam mouse_state_t ST_WAIT_BAT      = 4'd4;
    localparam mouse_state_t ST_WAIT_ID       = 4'd5;
    localparam mouse_state_t ST_SEND_EN       = 4'd6;
    localparam mouse_state_t ST_WAIT_EN_TX    = 4'd7;
    localparam mouse_state_t ST_WAIT_ACK2     = 4'd8;
    localparam mouse_state_t ST_STREAM_B0     = 4'd9;
    localparam mouse_state_t ST_STREAM_B1     = 4'd10;
    localparam mouse_state_t ST_STREAM_B2     = 4'd11;
    localparam mouse_state_t ST_STREAM_COMMIT = 4'd12;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;
    localparam int unsigned PKT_SYNC_BIT = 3;

    // Position of the next expected byte within a stream packet.
    localparam logic [1:0] PH_B0 = 2'd0;
    localparam logic [1:0] PH_B1 = 2'd1;
    localparam logic [1:0] PH_B2 = 2'd2;

    function automatic logic is_stream(input mouse_state_t st);
        return st inside {ST_STREAM_B0, ST_STREAM_B1, ST_STREAM_B2, ST_STREAM_COMMIT};
    endfunction

    function automatic logic is_timed_wait(input mouse_state_t st);
        return st inside {ST_WAIT_RST_TX, ST_WAIT_ACK1, ST_WAIT_BAT, ST_WAIT_ID,
                          ST_WAIT_EN_TX, ST_WAIT_ACK2};
    endfunction

endpackage

// File: rtl/mouse_packet_collector.sv
// Assembles 3-byte PS/2 stream packets and commits them atomically with a one-cycle interrupt.
module mouse_packet_collector
    import mouse_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       stream_en_i,
    input  logic [1:0] phase_i,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_i,
    input  logic [1:0] byte_err_i,
    output logic [7:0] status_o,
    output logic [7:0] dx_o,
    output logic [7:0] dy_o,
    output logic       irq_o
);

    logic [7:0] sh0_q, sh0_d, sh1_q, sh1_d;
    logic [7:0] status_q, status_d, dx_q, dx_d, dy_q, dy_d;
    logic       irq_q, irq_d;
    logic       good;

    assign good = stream_en_i && byte_valid_i && (byte_err_i == 2'b00);

    always_comb begin
        sh0_d    = sh0_q;
        sh1_d    = sh1_q;
        status_d = status_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        irq_d    = 1'b0;
        if (good) begin
            case (phase_i)
                PH_B0: if (byte_i[PKT_SYNC_BIT]) sh0_d = byte_i;
                PH_B1: sh1_d = byte_i;
                // Final byte bypasses its shadow so the packet lands together with the pulse.
                PH_B2: begin
                    status_d = sh0_q;
                    dx_d     = sh1_q;
                    dy_d     = byte_i;
                    irq_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh0_q    <= 8'h00;
            sh1_q    <= 8'h00;
            status_q <= 8'h00;
            dx_q     <= 8'h00;
            dy_q     <= 8'h00;
            irq_q    <= 1'b0;
        end else begin
            sh0_q    <= sh0_d;
            sh1_q    <= sh1_d;
            status_q <= status_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            irq_q    <= irq_d;
        end
    end

    assign status_o = status_q;
    assign dx_o     = dx_q;
    assign dy_o     = dy_q;
    assign irq_o    = irq_q;

endmodule

// File: rtl/mouse_master_sm.sv
// PS/2 mouse master: init handshake (FF/FA/AA/00/F4/FA) then stream packet collection.
// Define MOUSE_TIMEOUT_EN to abandon init wait states after TIMEOUT_CYCLES and restart.
module mouse_master_sm
    import mouse_pkg::*;
#(
    parameter int unsigned INIT_DELAY_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES    = 50_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic       BYTE_READY,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       SEND_INTERRUPT,
    output logic [3:0] MASTER_STATE
);

    mouse_state_t state_q, state_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [7:0]   tx_byte_q, tx_byte_d;
    logic         rx_good;
    logic         cnt_run;
    logic [1:0]   phase;

    assign rx_good = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:        if (cnt_q == INIT_DELAY_CYCLES) state_d = ST_SEND_RST;
            ST_SEND_RST:    state_d = ST_WAIT_RST_TX;
            ST_WAIT_RST_TX: if (BYTE_SENT) state_d = ST_WAIT_ACK1;
            ST_WAIT_ACK1:   if (BYTE_READY)
                                state_d = (rx_good && BYTE_READ == RSP_ACK) ? ST_WAIT_BAT : ST_INIT;
            ST_WAIT_BAT:    if (BYTE_READY)
                                state_d = (rx_good && BYTE_READ == RSP_BAT_OK) ? ST_WAIT_ID : ST_INIT;
            ST_WAIT_ID:     if (BYTE_READY)
                                state_d = (rx_good && BYTE_READ == RSP_ID) ? ST_SEND_EN : ST_INIT;
            ST_SEND_EN:     state_d = ST_WAIT_EN_TX;
            ST_WAIT_EN_TX:  if (BYTE_SENT) state_d = ST_WAIT_ACK2;
            ST_WAIT_ACK2:   if (BYTE_READY)
                                state_d = (rx_good && BYTE_READ == RSP_ACK) ? ST_STREAM_B0 : ST_INIT;
            // Commit cycle doubles as B0 so a back-to-back byte starts the next packet.
            ST_STREAM_B0, ST_STREAM_COMMIT:
                state_d = (rx_good && BYTE_READ[PKT_SYNC_BIT]) ? ST_STREAM_B1 : ST_STREAM_B0;
            ST_STREAM_B1:   if (BYTE_READY) state_d = rx_good ? ST_STREAM_B2 : ST_STREAM_B0;
            ST_STREAM_B2:   if (BYTE_READY) state_d = rx_good ? ST_STREAM_COMMIT : ST_STREAM_B0;
            default:        state_d = ST_INIT;
        endcase
`ifdef MOUSE_TIMEOUT_EN
        if (is_timed_wait(state_q) && state_d == state_q && cnt_q == TIMEOUT_CYCLES - 1) begin
            state_d = ST_INIT;
        end
`endif
    end

    always_comb begin
        cnt_run = (state_q == ST_INIT);
`ifdef MOUSE_TIMEOUT_EN
        cnt_run = cnt_run || is_timed_wait(state_q);
`endif
        if (state_d != state_q) cnt_d = 32'd0;
        else if (cnt_run)       cnt_d = cnt_q + 32'd1;
        else                    cnt_d = cnt_q;
    end

    always_comb begin
        tx_byte_d = tx_byte_q;
        if (state_d == ST_SEND_RST)     tx_byte_d = CMD_RESET;
        else if (state_d == ST_SEND_EN) tx_byte_d = CMD_ENABLE;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_INIT;
            cnt_q     <= 32'd0;
            tx_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    always_comb begin
        phase = PH_B0;
        if (state_q == ST_STREAM_B1)      phase = PH_B1;
        else if (state_q == ST_STREAM_B2) phase = PH_B2;
    end

    mouse_packet_collector u_collector (
        .clk_i        (CLK),
        .rst_ni       (RESET),
        .stream_en_i  (is_stream(state_q)),
        .phase_i      (phase),
        .byte_valid_i (BYTE_READY),
        .byte_i       (BYTE_READ),
        .byte_err_i   (BYTE_ERROR_CODE),
        .status_o     (MOUSE_STATUS),
        .dx_o         (MOUSE_DX),
        .dy_o         (MOUSE_DY),
        .irq_o        (SEND_INTERRUPT)
    );

    assign SEND_BYTE    = (state_q == ST_SEND_RST) || (state_q == ST_SEND_EN);
    assign BYTE_TO_SEND = tx_byte_q;
    assign READ_ENABLE  = !(state_q inside {ST_INIT, ST_SEND_RST, ST_SEND_EN});
    assign MASTER_STATE = state_q;

endmodule
